// File: rtl/rof_pkg.sv
// Shared types and constants for the rank-order filter unit.
package rof_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  localparam int unsigned ParamNLsb      = 0;
  localparam int unsigned ParamNWidth    = 8;
  localparam int unsigned ParamRankLsb   = 8;
  localparam int unsigned ParamRankWidth = 8;

  // Width able to hold any count from 0 to num inclusive.
  function automatic int unsigned cnt_width(input int unsigned num);
    return $clog2(num + 1);
  endfunction

endpackage

// File: rtl/rof_ge_counter.sv
// Counts selected window elements whose pixel is >= the trial value (unsigned).
module rof_ge_counter #(
  parameter int unsigned NUM   = 25,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic [NUM*PIX_W-1:0] window_i,
  input  logic [NUM-1:0]       sel_i,
  input  logic [PIX_W-1:0]     trial_i,
  output logic [CNT_W-1:0]     cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (sel_i[k] && (window_i[k*PIX_W +: PIX_W] >= trial_i)) begin
        cnt_o = cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rof_filter_unit.sv
// Masked rank-order filter: bit-serial MSB-first threshold search, one result bit per cycle.
// Optional o_count output is enabled by defining ROF_COUNT_OUT_EN.
module rof_filter_unit
  import rof_pkg::*;
#(
  parameter int unsigned MAX_N = 5,
  parameter int unsigned PIX_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    i_parameters,
  input  logic [MAX_N*MAX_N-1:0]         i_mask,
  input  logic [MAX_N*MAX_N*PIX_W-1:0]   i_window,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [PIX_W-1:0]               o_pixel,
  output logic                           o_valid,
  input  logic                           i_ready
`ifdef ROF_COUNT_OUT_EN
  ,
  output logic [cnt_width(MAX_N*MAX_N)-1:0] o_count
`endif
);

  localparam int unsigned NUM   = MAX_N * MAX_N;
  localparam int unsigned CNT_W = cnt_width(NUM);
  localparam int unsigned IDX_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  state_e                    state_q;
  logic                      ready_q, valid_q;
  logic [PIX_W-1:0]          pixel_q, res_q;
  logic [NUM*PIX_W-1:0]      win_q;
  logic [NUM-1:0]            sel_q;
  logic [ParamRankWidth-1:0] rank_q;
  logic [IDX_W-1:0]          bit_q;
`ifdef ROF_COUNT_OUT_EN
  logic [CNT_W-1:0]          count_q;
  logic [CNT_W-1:0]          sel_cnt;
`endif

  logic [ParamNWidth-1:0]    n_raw;
  logic [ParamRankWidth-1:0] rank_raw, rank_eff;
  logic [NUM-1:0]            sel_acc;
  logic [PIX_W-1:0]          trial;
  logic [CNT_W-1:0]          ge_cnt;
  logic                      rank_hit;
  logic                      unused_params;

  assign n_raw         = i_parameters[ParamNLsb +: ParamNWidth];
  assign rank_raw      = i_parameters[ParamRankLsb +: ParamRankWidth];
  assign unused_params = ^i_parameters[31:16];
  assign rank_eff      = (rank_raw == '0) ? ParamRankWidth'(1) : rank_raw;

  // Fold the N clamp into the mask at accept time so the search sees one vector.
  always_comb begin
    int unsigned n_eff;
    if ((n_raw != '0) && (32'(n_raw) <= MAX_N)) n_eff = 32'(n_raw);
    else n_eff = MAX_N;
    sel_acc = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      sel_acc[k] = i_mask[k] && ((k / MAX_N) < n_eff) && ((k % MAX_N) < n_eff);
    end
`ifdef ROF_COUNT_OUT_EN
    sel_cnt = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (sel_acc[k]) sel_cnt = sel_cnt + CNT_W'(1);
    end
`endif
  end

  assign trial    = res_q | (PIX_W'(1) << bit_q);
  assign rank_hit = ({{ParamRankWidth{1'b0}}, ge_cnt} >= {{CNT_W{1'b0}}, rank_q});

  rof_ge_counter #(
    .NUM  (NUM),
    .PIX_W(PIX_W),
    .CNT_W(CNT_W)
  ) u_ge_counter (
    .window_i(win_q),
    .sel_i   (sel_q),
    .trial_i (trial),
    .cnt_o   (ge_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      pixel_q <= '0;
      res_q   <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      rank_q  <= '0;
      bit_q   <= '0;
`ifdef ROF_COUNT_OUT_EN
      count_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            win_q   <= i_window;
            sel_q   <= sel_acc;
            rank_q  <= rank_eff;
            res_q   <= '0;
            bit_q   <= IDX_W'(PIX_W - 1);
            ready_q <= 1'b0;
            state_q <= StSearch;
`ifdef ROF_COUNT_OUT_EN
            count_q <= sel_cnt;
`endif
          end
        end
        StSearch: begin
          if (rank_hit) res_q <= trial;
          if (bit_q == '0) begin
            pixel_q <= rank_hit ? trial : res_q;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            bit_q <= bit_q - IDX_W'(1);
          end
        end
        StDone: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_pixel = pixel_q;
`ifdef ROF_COUNT_OUT_EN
  assign o_count = count_q;
`endif

endmodule

// File: tb/tb_rof_filter_unit.sv
// Scoreboard bench for rof_filter_unit: directed windows, monitor-side result checking.
module tb_rof_filter_unit;

  localparam int unsigned MAX_N = 5;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned NUM   = MAX_N * MAX_N;
  localparam int unsigned CNT_W = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [31:0]            i_parameters = '0;
  logic [NUM-1:0]         i_mask = '0;
  logic [NUM*PIX_W-1:0]   i_window = '0;
  logic                   i_valid = 1'b0;
  logic                   o_ready;
  logic [PIX_W-1:0]       o_pixel;
  logic                   o_valid;
  logic                   i_ready = 1'b1;
`ifdef ROF_COUNT_OUT_EN
  logic [CNT_W-1:0]       o_count;
`endif

  rof_filter_unit #(
    .MAX_N(MAX_N),
    .PIX_W(PIX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_parameters(i_parameters),
    .i_mask      (i_mask),
    .i_window    (i_window),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_pixel     (o_pixel),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
`ifdef ROF_COUNT_OUT_EN
    ,
    .o_count     (o_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [PIX_W-1:0] pix;
    int               cnt;
    int               acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  localparam logic [NUM-1:0] MaskAll = {NUM{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: latency on first valid cycle, value on the handshake cycle.
  always @(negedge clk) begin
    if (rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got pixel %0d, expected no result", o_pixel);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk({"latency ", exp_q[0].name}, 64'(cyc - exp_q[0].acc_cyc), 64'(PIX_W));
        end
        if (i_ready) begin
          chk({"pixel ", exp_q[0].name}, 64'(o_pixel), 64'(exp_q[0].pix));
`ifdef ROF_COUNT_OUT_EN
          chk({"count ", exp_q[0].name}, 64'(o_count), 64'(exp_q[0].cnt));
`endif
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  function automatic logic [NUM*PIX_W-1:0] base_win();
    logic [NUM*PIX_W-1:0] w;
    w = {NUM{8'hFF}};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*MAX_N+c)*PIX_W +: PIX_W] = 8'(10 * (r*3 + c + 1));
      end
    end
    return w;
  endfunction

  // Called just after a rising edge; returns #1 after the accepting edge.
  task automatic accept(input string name, input logic [NUM*PIX_W-1:0] win,
                        input logic [NUM-1:0] m, input logic [7:0] n, input logic [7:0] rank,
                        input logic [7:0] epix, input int ecnt);
    int t = 0;
    while (!o_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_ready) timeout({"ready ", name});
    i_window     = win;
    i_mask       = m;
    i_parameters = {16'hABCD, rank, n};
    i_valid      = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    exp_q.push_back('{name, epix, ecnt, cyc});
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      timeout({"result ", name});
      exp_q.delete();
    end
    chk({"idle_ready ", name}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    logic [NUM*PIX_W-1:0] w;
    logic [PIX_W-1:0]     held;
    int                   t;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_pixel", 64'(o_pixel), 64'd0);
    chk("reset_ready", 64'(o_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    w = base_win();
    accept("median", w, MaskAll, 8'd3, 8'd5, 8'd50, 9);  wait_done("median");
    accept("rank1", w, MaskAll, 8'd3, 8'd1, 8'd90, 9);   wait_done("rank1");
    accept("rank9", w, MaskAll, 8'd3, 8'd9, 8'd10, 9);   wait_done("rank9");
    accept("rank0", w, MaskAll, 8'd3, 8'd0, 8'd90, 9);   wait_done("rank0");
    accept("rank10", w, MaskAll, 8'd3, 8'd10, 8'd0, 9);  wait_done("rank10");
    accept("n9_max", w, MaskAll, 8'd9, 8'd1, 8'd255, 25); wait_done("n9_max");

    w[12*PIX_W +: PIX_W] = 8'd77;
    accept("n0_bit12", w, NUM'(1) << 12, 8'd0, 8'd1, 8'd77, 1); wait_done("n0_bit12");
    accept("mask0", w, '0, 8'd0, 8'd1, 8'd0, 0);              wait_done("mask0");

    // Backpressure: result must hold while downstream stalls.
    w = base_win();
    i_ready = 1'b0;
    accept("backpressure", w, MaskAll, 8'd3, 8'd5, 8'd50, 9);
    t = 0;
    while (!o_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_valid) timeout("bp_valid");
    held = o_pixel;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 64'(o_valid), 64'd1);
      chk("bp_pixel_hold", 64'(o_pixel), 64'(held));
      chk("bp_ready_low", 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(o_ready), 64'd1);
    chk("bp_release_valid", 64'(o_valid), 64'd0);

    // Snapshot: inputs changed during the search must not matter.
    accept("snapshot", w, MaskAll, 8'd3, 8'd5, 8'd50, 9);
    i_parameters = {16'h0, 8'd1, 8'd3};
    i_window     = '0;
    wait_done("snapshot");

    // Reset sampled on the 4th search edge.
    accept("reset_victim", w, MaskAll, 8'd3, 8'd1, 8'd90, 9);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_pixel", 64'(o_pixel), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    accept("post_reset", w, MaskAll, 8'd3, 8'd9, 8'd10, 9);
    wait_done("post_reset");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
